lsu_misalign_ctrl: RTL and testbench

Load/store address-phase controller for the EX stage. It takes one load/store request per instruction from EX and issues aligned word transactions on the data bus. Misaligned accesses are split into two bus transactions. It drives `lsu_addr_incr_req_o`/`lsu_addr_last_o` into the ALU operand-A mux, so the ALU computes the second word address (last address + 4), and it returns aligned, extended load data to writeback.

---
 rtl/ibex_pkg.sv | 55 +++++
 rtl/lsu_misalign_ctrl_rdata_align.sv | 45 ++++
 rtl/lsu_misalign_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_misalign_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared LSU types: address-phase FSM encoding, access-size codes and byte-lane helpers.
package ibex_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT_MIS,
    WAIT_RVALID_MIS,
    WAIT_GNT,
    WAIT_RVALID
  } ls_fsm_e;

  localparam logic [1:0] LSU_WORD = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_BYTE = 2'b10;

  // Accesses that cross a word boundary need two bus transactions.
  function automatic logic is_split(input logic [1:0] lsu_type, input logic [1:0] off);
    return ((lsu_type == LSU_WORD) && (off != 2'b00)) ||
           ((lsu_type == LSU_HALF) && (off == 2'b11));
  endfunction

  function automatic logic [3:0] be_first(input logic [1:0] lsu_type, input logic [1:0] off);
    case (lsu_type)
      LSU_WORD: return 4'b1111 << off;
      LSU_HALF: return 4'b0011 << off;
      default:  return 4'b0001 << off;
    endcase
  endfunction

  function automatic logic [3:0] be_second(input logic [1:0] lsu_type, input logic [1:0] off);
    if (lsu_type == LSU_HALF) begin
      return 4'b0001;
    end
    if (lsu_type == LSU_WORD) begin
      case (off)
        2'b01:   return 4'b0001;
        2'b10:   return 4'b0011;
        2'b11:   return 4'b0111;
        default: return 4'b0000;
      endcase
    end
    return 4'b0000;
  endfunction

  // Rotate store data left by whole bytes so byte 0 lands on lane 'off'.
  function automatic logic [31:0] rotl_lanes(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'b01:   return {w[23:0], w[31:24]};
      2'b10:   return {w[15:0], w[31:16]};
      2'b11:   return {w[7:0],  w[31:8]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/lsu_misalign_ctrl_rdata_align.sv
// Combinational load-data alignment: stitches split responses, shifts to bit 0, then extends.
module lsu_rdata_align
  import ibex_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic        sign_ext_i,
  input  logic [31:0] rdata_q_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] lsu_rdata_o
);

  logic [31:0] split_word;
  logic [31:0] aligned;

  // Low bytes come from the first response, high bytes from the second.
  always_comb begin
    case (off_i)
      2'b01:   split_word = {data_rdata_i[7:0],  rdata_q_i[31:8]};
      2'b10:   split_word = {data_rdata_i[15:0], rdata_q_i[31:16]};
      2'b11:   split_word = {data_rdata_i[23:0], rdata_q_i[31:24]};
      default: split_word = data_rdata_i;
    endcase
  end

  always_comb begin
    aligned = data_rdata_i >> {off_i, 3'b000};
    if (is_split(type_i, off_i)) begin
      if (type_i == LSU_WORD) begin
        aligned = split_word;
      end else begin
        aligned = {16'h0000, data_rdata_i[7:0], rdata_q_i[31:24]};
      end
    end
  end

  always_comb begin
    case (type_i)
      LSU_HALF: lsu_rdata_o = {{16{sign_ext_i & aligned[15]}}, aligned[15:0]};
      LSU_BYTE: lsu_rdata_o = {{24{sign_ext_i & aligned[7]}},  aligned[7:0]};
      default:  lsu_rdata_o = aligned;
    endcase
  end

endmodule

// File: rtl/lsu_misalign_ctrl.sv
// EX-stage load/store address-phase controller; splits boundary-crossing accesses in two.
// Define LSU_MISALIGN_SPLIT_EN to enable splitting; otherwise such accesses fail immediately.
module lsu_misalign_ctrl
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] adder_result_ex_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_addr_incr_req_o,
  output logic [31:0] lsu_addr_last_o,
  output logic        lsu_req_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rdata_valid_o,
  output logic        lsu_busy_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  ls_fsm_e     state_q, state_d;
  logic        we_q, sign_ext_q, split_q, err_q;
  logic [1:0]  type_q, off_q;
  logic [31:0] wdata_q, addr_last_q, rdata_q;

  logic [1:0]  off_in;
  logic        split_in, split_rej, accept, issue_idle, fin_err;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
  assign lsu_addr_incr_req_o = ((state_q == WAIT_RVALID_MIS) && data_rvalid_i) ||
                               ((state_q == WAIT_GNT) && split_q);
`else
  localparam bit SplitEn = 1'b0;
  assign lsu_addr_incr_req_o = 1'b0;
`endif

  assign off_in     = adder_result_ex_i[1:0];
  assign split_in   = SplitEn && is_split(lsu_type_i, off_in);
  assign split_rej  = !SplitEn && is_split(lsu_type_i, off_in);
  assign accept     = (state_q == IDLE) && lsu_req_i;
  assign issue_idle = accept && !split_rej;
  assign fin_err    = err_q | data_err_i;

  assign data_addr_o     = {adder_result_ex_i[31:2], 2'b00};
  assign lsu_addr_last_o = addr_last_q;
  assign lsu_busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue_idle) begin
          if (data_gnt_i) begin
            state_d = split_in ? WAIT_RVALID_MIS : WAIT_RVALID;
          end else begin
            state_d = split_in ? WAIT_GNT_MIS : WAIT_GNT;
          end
        end
      end
      WAIT_GNT_MIS:    if (data_gnt_i) state_d = WAIT_RVALID_MIS;
      WAIT_RVALID_MIS: if (data_rvalid_i) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
      WAIT_GNT:        if (data_gnt_i) state_d = WAIT_RVALID;
      WAIT_RVALID:     if (data_rvalid_i) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  // Access attributes are frozen at acceptance so the bus side stays stable while waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= 1'b0;
      type_q      <= 2'b00;
      sign_ext_q  <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      addr_last_q <= 32'h0;
      rdata_q     <= 32'h0;
    end else if (accept) begin
      we_q        <= lsu_we_i;
      type_q      <= lsu_type_i;
      sign_ext_q  <= lsu_sign_ext_i;
      off_q       <= off_in;
      wdata_q     <= lsu_wdata_i;
      split_q     <= split_in;
      err_q       <= 1'b0;
      addr_last_q <= adder_result_ex_i;
    end else if ((state_q == WAIT_RVALID_MIS) && data_rvalid_i) begin
      rdata_q <= data_rdata_i;
      err_q   <= data_err_i;
    end
  end

  always_comb begin
    data_req_o        = 1'b0;
    data_we_o         = we_q;
    data_be_o         = 4'b0000;
    data_wdata_o      = rotl_lanes(wdata_q, off_q);
    lsu_req_done_o    = 1'b0;
    lsu_rdata_valid_o = 1'b0;
    load_err_o        = 1'b0;
    store_err_o       = 1'b0;
    case (state_q)
      IDLE: begin
        data_req_o     = issue_idle;
        data_we_o      = lsu_we_i;
        data_wdata_o   = rotl_lanes(lsu_wdata_i, off_in);
        data_be_o      = issue_idle ? be_first(lsu_type_i, off_in) : 4'b0000;
        lsu_req_done_o = accept && split_rej;
        load_err_o     = accept && split_rej && !lsu_we_i;
        store_err_o    = accept && split_rej && lsu_we_i;
      end
      WAIT_GNT_MIS: begin
        data_req_o = 1'b1;
        data_be_o  = be_first(type_q, off_q);
      end
      WAIT_RVALID_MIS: begin
        data_req_o = data_rvalid_i;
        data_be_o  = data_rvalid_i ? be_second(type_q, off_q) : 4'b0000;
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        data_be_o  = split_q ? be_second(type_q, off_q) : be_first(type_q, off_q);
      end
      WAIT_RVALID: begin
        lsu_req_done_o    = data_rvalid_i;
        lsu_rdata_valid_o = data_rvalid_i && !we_q && !fin_err;
        load_err_o        = data_rvalid_i && !we_q && fin_err;
        store_err_o       = data_rvalid_i && we_q && fin_err;
      end
      default: ;
    endcase
  end

  lsu_rdata_align u_rdata_align (
    .off_i        (off_q),
    .type_i       (type_q),
    .sign_ext_i   (sign_ext_q),
    .rdata_q_i    (rdata_q),
    .data_rdata_i (data_rdata_i),
    .lsu_rdata_o  (lsu_rdata_o)
  );

endmodule

// File: tb/tb_lsu_misalign_ctrl.sv
// Directed bench for lsu_misalign_ctrl; split scenarios run when LSU_MISALIGN_SPLIT_EN is defined.
module tb_lsu_misalign_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we, lsu_sign_ext;
  logic [1:0]  lsu_type;
  logic [31:0] ex_addr, adder, lsu_wdata;
  logic        incr, done, rvalid_o, busy, load_err, store_err;
  logic [31:0] last, rdata;
  logic        data_req, data_gnt, data_rvalid, data_err, data_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // ALU operand-A mux: second-phase address is last + 4.
  assign adder = incr ? last + 32'd4 : ex_addr;

  lsu_misalign_ctrl dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .lsu_req_i           (lsu_req),
    .lsu_we_i            (lsu_we),
    .lsu_type_i          (lsu_type),
    .lsu_sign_ext_i      (lsu_sign_ext),
    .adder_result_ex_i   (adder),
    .lsu_wdata_i         (lsu_wdata),
    .lsu_addr_incr_req_o (incr),
    .lsu_addr_last_o     (last),
    .lsu_req_done_o      (done),
    .lsu_rdata_o         (rdata),
    .lsu_rdata_valid_o   (rvalid_o),
    .lsu_busy_o          (busy),
    .load_err_o          (load_err),
    .store_err_o         (store_err),
    .data_req_o          (data_req),
    .data_gnt_i          (data_gnt),
    .data_rvalid_i       (data_rvalid),
    .data_err_i          (data_err),
    .data_addr_o         (data_addr),
    .data_we_o           (data_we),
    .data_be_o           (data_be),
    .data_wdata_o        (data_wdata),
    .data_rdata_i        (data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00; lsu_sign_ext = 1'b0;
    ex_addr = 32'h0; lsu_wdata = 32'h0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'h0;
  endtask

  task automatic issue(input logic we, input logic [1:0] t, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic gnt);
    lsu_req = 1'b1; lsu_we = we; lsu_type = t; lsu_sign_ext = sx;
    ex_addr = a; lsu_wdata = wd; data_gnt = gnt;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_req", data_req, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last, 32'h0);
    chk("rst_incr", incr, 0);
    chk("rst_valid", rvalid_o, 0);
    step(); step();
    rst_n = 1'b1;

    // Aligned word load, same-cycle grant
    step(); issue(0, 2'b00, 0, 32'h1000, 32'h0, 1); #2;
    chk("wl_req", data_req, 1);
    chk("wl_addr", data_addr, 32'h1000);
    chk("wl_be", data_be, 4'b1111);
    chk("wl_we", data_we, 0);
    chk("wl_done_early", done, 0);
    step(); clr_in(); data_rvalid = 1; data_rdata = 32'hDEADBEEF; ex_addr = 32'h1000; #2;
    chk("wl_done", done, 1);
    chk("wl_rdata", rdata, 32'hDEADBEEF);
    chk("wl_valid", rvalid_o, 1);
    chk("wl_busy", busy, 1);
    step(); clr_in(); #2;
    chk("wl_idle", busy, 0);
    chk("wl_done_clr", done, 0);

    // Byte load offset 1, sign extended
    step(); issue(0, 2'b10, 1, 32'h3001, 32'h0, 1); #2;
    chk("bl_be", data_be, 4'b0010);
    chk("bl_addr", data_addr, 32'h3000);
    step(); clr_in(); ex_addr = 32'h3001; data_rvalid = 1; data_rdata = 32'h0000F200; #2;
    chk("bl_rdata", rdata, 32'hFFFFFFF2);
    chk("bl_valid", rvalid_o, 1);
    chk("bl_last", last, 32'h3001);

    // Signed half load offset 2
    step(); issue(0, 2'b01, 1, 32'h5002, 32'h0, 1); #2;
    chk("hs_be", data_be, 4'b1100);
    step(); clr_in(); ex_addr = 32'h5002; data_rvalid = 1; data_rdata = 32'h80010000; #2;
    chk("hs_rdata", rdata, 32'hFFFF8001);

    // Unsigned half load offset 1 (stays in one word)
    step(); issue(0, 2'b01, 0, 32'h5001, 32'h0, 1); #2;
    chk("hu_be", data_be, 4'b0110);
    chk("hu_req", data_req, 1);
    step(); clr_in(); ex_addr = 32'h5001; data_rvalid = 1; data_rdata = 32'h00ABCD00; #2;
    chk("hu_rdata", rdata, 32'h0000ABCD);

    // Byte store offset 3, grant delayed one cycle, error response
    step(); issue(1, 2'b10, 0, 32'h6003, 32'h000000A5, 0); #2;
    chk("bs_req", data_req, 1);
    chk("bs_be", data_be, 4'b1000);
    chk("bs_wdata", data_wdata, 32'hA5000000);
    step(); lsu_req = 0; data_gnt = 1; #2;
    chk("bs_hold_req", data_req, 1);
    chk("bs_hold_addr", data_addr, 32'h6000);
    chk("bs_hold_be", data_be, 4'b1000);
    chk("bs_hold_wdata", data_wdata, 32'hA5000000);
    chk("bs_hold_we", data_we, 1);
    step(); data_gnt = 0; data_rvalid = 1; data_err = 1; #2;
    chk("bs_done", done, 1);
    chk("bs_serr", store_err, 1);
    chk("bs_lerr", load_err, 0);
    chk("bs_valid", rvalid_o, 0);
    step(); clr_in(); #2;

    // Late rvalid while idle is dropped
    data_rvalid = 1; data_rdata = 32'h12345678; #2;
    chk("late_done", done, 0);
    chk("late_valid", rvalid_o, 0);
    step(); clr_in(); #2;
    chk("late_busy", busy, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Misaligned word store
    step(); issue(1, 2'b00, 0, 32'h1002, 32'hAABBCCDD, 1); #2;
    chk("ms_p1_addr", data_addr, 32'h1000);
    chk("ms_p1_be", data_be, 4'b1100);
    chk("ms_p1_wdata", data_wdata, 32'hCCDDAABB);
    chk("ms_p1_incr", incr, 0);
    step(); lsu_req = 0; data_gnt = 1; data_rvalid = 1; #2;
    chk("ms_p2_incr", incr, 1);
    chk("ms_p2_req", data_req, 1);
    chk("ms_p2_addr", data_addr, 32'h1004);
    chk("ms_p2_be", data_be, 4'b0011);
    chk("ms_p2_wdata", data_wdata, 32'hCCDDAABB);
    chk("ms_p2_done", done, 0);
    step(); data_gnt = 0; data_rvalid = 1; #2;
    chk("ms_done", done, 1);
    chk("ms_serr", store_err, 0);
    step(); clr_in(); #2;

    // Signed split half load with wait states
    step(); issue(0, 2'b01, 1, 32'h2003, 32'h0, 0); #2;
    chk("mh_p1_be", data_be, 4'b1000);
    step(); lsu_req = 0; data_gnt = 1; #2;
    chk("mh_gw_req", data_req, 1);
    chk("mh_gw_be", data_be, 4'b1000);
    step(); data_gnt = 0; data_rvalid = 1; data_rdata = 32'h80112233; #2;
    chk("mh_p2_be", data_be, 4'b0001);
    chk("mh_p2_addr", data_addr, 32'h2004);
    step(); data_rvalid = 0; data_gnt = 1; #2;
    chk("mh_wg_incr", incr, 1);
    chk("mh_wg_be", data_be, 4'b0001);
    step(); data_gnt = 0; data_rvalid = 1; data_rdata = 32'h445566FF; #2;
    chk("mh_rdata", rdata, 32'hFFFFFF80);
    chk("mh_valid", rvalid_o, 1);
    step(); clr_in(); #2;

    // Split word load with first-response error
    step(); issue(0, 2'b00, 0, 32'h1001, 32'h0, 1); #2;
    step(); lsu_req = 0; data_rvalid = 1; data_err = 1; data_gnt = 1; #2;
    chk("me_p2_req", data_req, 1);
    step(); data_err = 0; data_gnt = 0; data_rvalid = 1; #2;
    chk("me_done", done, 1);
    chk("me_lerr", load_err, 1);
    chk("me_valid", rvalid_o, 0);
    step(); clr_in(); #2;

    // Reset in WAIT_RVALID_MIS
    step(); issue(0, 2'b00, 0, 32'h7002, 32'h0, 1); #2;
    step(); clr_in(); ex_addr = 32'h7002; rst_n = 0; #2;
    chk("mr_busy", busy, 0);
    step(); rst_n = 1;
    step(); data_rvalid = 1; #2;
    chk("mr_done", done, 0);
    chk("mr_valid", rvalid_o, 0);
    chk("mr_req", data_req, 0);
    step(); clr_in(); #2;
`else
    // Misaligned word store without split support
    step(); issue(1, 2'b00, 0, 32'h1002, 32'hAABBCCDD, 1); #2;
    chk("nr_req", data_req, 0);
    chk("nr_done", done, 1);
    chk("nr_serr", store_err, 1);
    chk("nr_lerr", load_err, 0);
    chk("nr_incr", incr, 0);
    step(); clr_in(); #2;
    chk("nr_busy", busy, 0);

    // Misaligned half load without split support
    step(); issue(0, 2'b01, 1, 32'h2003, 32'h0, 1); #2;
    chk("nh_req", data_req, 0);
    chk("nh_done", done, 1);
    chk("nh_lerr", load_err, 1);
    chk("nh_valid", rvalid_o, 0);
    step(); clr_in(); #2;
    chk("nh_busy", busy, 0);

    // Reset while waiting for an aligned response
    step(); issue(0, 2'b00, 0, 32'h7000, 32'h0, 1); #2;
    step(); clr_in(); ex_addr = 32'h7000; rst_n = 0; #2;
    chk("ar_busy", busy, 0);
    step(); rst_n = 1;
    step(); data_rvalid = 1; #2;
    chk("ar_done", done, 0);
    chk("ar_valid", rvalid_o, 0);
    step(); clr_in(); #2;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
